// File: rtl/restoring_div_18b_if.sv
// restoring_div_18b_if
//   Start/done handshake bundle for the 18-bit sequential divider.
//   master : drives start/sign/a/b, observes q/r/busy/done (requester side)
//   slave  : the divider itself
//   start  request pulse, sampled on rising clk
//   sign   1 = two's-complement divide, 0 = unsigned
//   a, b   dividend / divisor (18 bit)
//   q, r   quotient / remainder, registered
//   busy   operation in flight
//   done   one-cycle result-valid pulse
interface restoring_div_18b_if;
  logic        start;
  logic        sign;
  logic [17:0] a;
  logic [17:0] b;
  logic [17:0] q;
  logic [17:0] r;
  logic        busy;
  logic        done;

  modport master (output start, sign, a, b, input q, r, busy, done);
  modport slave  (input start, sign, a, b, output q, r, busy, done);
endinterface

// File: rtl/restoring_div_18b.sv
// restoring_div_18b
//   Sequential 18-bit radix-2 restoring divider, signed or unsigned, with
//   RISC-V M-extension results for divide-by-zero and signed overflow.
//   One quotient bit per cycle: 18 CALC cycles, one FIX cycle, one DONE cycle.
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    restoring_div_18b_if.slave (start/sign/a/b in, q/r/busy/done out)

// Block carry-lookahead adder: ripple inside 4-bit groups, lookahead between
// groups. cout_o is the true carry out of the MSB.
module cla_adder #(
  parameter int W = 19
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);
  localparam int NG = (W + 3) / 4;

  logic [W-1:0] g, p, c;
  logic         carry, cr, grp_g, grp_p;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  always_comb begin
    c     = '0;
    carry = cin_i;
    cr    = 1'b0;
    grp_g = 1'b0;
    grp_p = 1'b1;
    for (int gi = 0; gi < NG; gi++) begin
      grp_g = 1'b0;
      grp_p = 1'b1;
      cr    = carry;
      for (int k = 0; k < 4; k++) begin
        if (gi * 4 + k < W) begin
          c[gi*4+k] = cr;
          cr        = g[gi*4+k] | (p[gi*4+k] & cr);
          grp_g     = g[gi*4+k] | (p[gi*4+k] & grp_g);
          grp_p     = grp_p & p[gi*4+k];
        end
      end
      carry = grp_g | (grp_p & carry);
    end
  end

  assign sum_o  = p ^ c;
  assign cout_o = carry;
endmodule

module restoring_div_18b (
  input  logic               clk,
  input  logic               rst_n,
  restoring_div_18b_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e      state_q;
  logic [17:0] dvd_q;     // dividend shifting out / quotient shifting in
  logic [17:0] dsr_q;     // divisor magnitude
  logic [18:0] prem_q;    // partial remainder
  logic [4:0]  cnt_q;
  logic        negq_q, negr_q;
  logic [17:0] q_q, r_q;
  logic        busy_q, done_q;

  logic [17:0] a_abs, b_abs;
  logic        ovf;
  logic [18:0] prem_sh, trial;
  logic        no_borrow;

  assign a_abs = (bus.sign & bus.a[17]) ? -bus.a : bus.a;
  assign b_abs = (bus.sign & bus.b[17]) ? -bus.b : bus.b;
  assign ovf   = bus.sign && (bus.a == 18'h20000) && (bus.b == 18'h3FFFF);

  // The shifted remainder can reach 2^19-1 while the divisor is below 2^18,
  // so the 19-bit difference's MSB is not a reliable sign; the adder's carry
  // out (no borrow) is used to decide whether the trial subtraction fits.
  assign prem_sh = {prem_q[17:0], dvd_q[17]};

  cla_adder #(.W(19)) u_sub (
    .a_i   (prem_sh),
    .b_i   (~{1'b0, dsr_q}),
    .cin_i (1'b1),
    .sum_o (trial),
    .cout_o(no_borrow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dsr_q   <= '0;
      prem_q  <= '0;
      cnt_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
            // Special cases park their results in the datapath registers so
            // FIX writes them out through the same path, sign fix disabled.
            if (bus.b == 18'd0) begin
              dvd_q   <= '1;
              prem_q  <= {1'b0, bus.a};
              state_q <= FIX;
            end else if (ovf) begin
              dvd_q   <= 18'h20000;
              prem_q  <= '0;
              state_q <= FIX;
            end else begin
              dvd_q   <= a_abs;
              dsr_q   <= b_abs;
              prem_q  <= '0;
              negq_q  <= bus.sign & (bus.a[17] ^ bus.b[17]);
              negr_q  <= bus.sign & bus.a[17];
              state_q <= CALC;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          dvd_q  <= {dvd_q[16:0], no_borrow};
          prem_q <= no_borrow ? trial : prem_sh;
          cnt_q  <= cnt_q + 5'd1;
          if (cnt_q == 5'd17) state_q <= FIX;
        end
        FIX: begin
          q_q     <= negq_q ? -dvd_q : dvd_q;
          r_q     <= negr_q ? -prem_q[17:0] : prem_q[17:0];
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.q    = q_q;
  assign bus.r    = r_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: doc/restoring_div_18b.md
# restoring_div_18b

Sequential 18-bit integer divider; the inverse of the 18-bit Karatsuba multiplier datapath in the MULTIPLIER/ARITH area. It computes quotient and remainder of two 18-bit operands, signed or unsigned, with one radix-2 restoring step per cycle. It uses the same start/done handshake as the multiplier sub-blocks. The RISC-V divide unit instantiates it as the 18-bit building block. Results follow RISC-V M-extension semantics for divide-by-zero and signed overflow.

## Interface
- No parameters (width fixed at 18).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; sampled on rising edge.
- sign  in  1  1 = signed (two's complement) divide, 0 = unsigned; sampled with start.
- a  in  18  dividend; sampled with start.
- b  in  18  divisor; sampled with start.
- q  out  18  quotient, registered.
- r  out  18  remainder, registered.
- busy  out  1  high while an operation is in flight (CALC or FIX).
- done  out  1  one-cycle pulse; q/r are valid from that cycle on.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE with start=1 latches a, b and sign:
  - Divisor b==0 → preset q=0x3FFFF, r=a; go to FIX.
  - sign=1, a==0x20000, b==0x3FFFF → preset q=0x20000, r=0; go to FIX.
  - Otherwise latch the magnitudes |a| and |b| (raw values if unsigned), plus neg_q = sign & (a[17]^b[17]) and neg_r = sign & a[17]; clear the 19-bit partial remainder; clear count; go to CALC.
- CALC, each cycle, one restoring step:
  - Shift {prem, dividend} left by 1.
  - Compute trial = prem − {1'b0,|b|} on a 19-bit cla_adder in sub mode.
  - If trial is non-negative, prem = trial and the quotient LSB is 1; else prem is unchanged and the LSB is 0.
  - count increments; after the 18th step go to FIX.
- FIX: write outputs.
  - q = neg_q ? −quot : quot.
  - r = neg_r ? −prem[17:0] : prem[17:0].
  - Special cases write their preset values unchanged.
  - Go to DONE.
- DONE: done=1 for exactly this cycle. Next state is IDLE, or CALC/FIX if start=1.
- start is ignored in CALC and FIX: no restart, and operands are not re-latched.
- Invariant for non-special cases: a == q·b + r, |r| < |b|, and sign(r) equals sign(a) or r==0.
- q and r hold their last written values until the next FIX; they never change during CALC.

## Timing
- Reset (async assert, sync deassert externally): state=IDLE, q=0, r=0, done=0, busy=0, count=0.
- Normal latency, with start sampled at edge k:
  - busy is high after edge k through edge k+19.
  - Outputs are written at edge k+19; done is high during the cycle between edges k+19 and k+20.
  - Throughput is one result per 20 cycles. Back-to-back issue is allowed by asserting start during the DONE cycle.
- Special-case latency: FIX is entered at edge k; outputs are written and done is high after edge k+1.
- rst_n asserted mid-operation: operation is abandoned; all outputs and state return to reset values immediately. No done pulse is produced.
- start held high continuously: one operation per 20 cycles, with each new operand set sampled in the DONE cycle.

## Test plan
- Unsigned: sign=0, a=100, b=7 → q=14, r=2. done pulses exactly 20 cycles after the start edge; busy is high for 19 cycles.
- Signed: sign=1, a=0x3FF9C (−100), b=7 → q=0x3FFF2 (−14), r=0x3FFFE (−2). Also a=100, b=0x3FFF9 (−7) → q=0x3FFF2, r=2.
- Divide-by-zero and overflow:
  - a=5, b=0 → q=0x3FFFF, r=5, with done 2 cycles after start.
  - sign=1, a=0x20000, b=0x3FFFF → q=0x20000, r=0.
- Extremes: unsigned 0x3FFFF/1 → q=0x3FFFF, r=0; unsigned 3/0x3FFFF → q=0, r=3.
- Handshake:
  - Pulse start again at cycle k+5 with different operands → ignored; the result matches the first operand set.
  - Start in the DONE cycle → second result arrives 20 cycles later.
- Reset mid-operation: assert rst_n=0 at cycle k+10 → q=r=0 and busy=done=0 immediately. After release, a fresh 100/7 produces the correct result.
- Random regression of 10k mixed signed/unsigned pairs checked against a reference model, including b=0 and the overflow case.
